// File: rtl/puf_result_packer.sv
// PUF result packer: serial response bits to MSB-first bytes,
// written sequentially into the result memory.
module puf_result_packer #(
  parameter int ADDR_WIDTH = 13,
  parameter int MAX_BYTES  = 8192
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   byte_count,
  input  logic                  abort,
  input  logic                  bit_valid,
  input  logic                  bit_data,
  output logic                  bit_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [7:0]            mem_din,
  output logic                  busy,
  output logic                  done,
  input  logic                  done_clear,
  output logic [ADDR_WIDTH:0]   bytes_written,
  output logic [ADDR_WIDTH+3:0] ones_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH:0] MAXB =
    (ADDR_WIDTH+1)'(MAX_BYTES);

  state_t                  state_q;
  state_t                  state_d;
  logic [ADDR_WIDTH:0]     target_q;
  logic [2:0]              bit_cnt_q;
  logic [6:0]              shreg_q;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q;
  logic [ADDR_WIDTH:0]     tgt_clamp;
  logic [ADDR_WIDTH:0]     bw_inc;
  logic [ADDR_WIDTH+3:0]   ones_inc;
  logic                    xfer;
  logic                    last_bit;
  logic                    wr_last;

  // Clamp the requested length to the memory capacity
  always_comb begin
    tgt_clamp = byte_count;
    if (byte_count > MAXB) tgt_clamp = MAXB;
  end

  // Transfer decode and counter increments
  always_comb begin
    xfer     = bit_valid & bit_ready;
    last_bit = xfer & (bit_cnt_q == 3'd7);
    bw_inc   = bytes_written + 1'b1;
    wr_last  = (bw_inc == target_q);
    ones_inc = ones_count
             + {{(ADDR_WIDTH+3){1'b0}}, bit_data};
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (tgt_clamp == '0) state_d = S_DONE;
          else                 state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (abort)         state_d = S_DONE;
        else if (last_bit) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (abort || wr_last) state_d = S_DONE;
        else                  state_d = S_COLLECT;
      end
      S_DONE: begin
        if (done_clear) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status flags decoded straight from the state register
  always_comb begin
    bit_ready = (state_q == S_COLLECT);
    busy      = (state_q == S_COLLECT)
              | (state_q == S_WRITE);
    done      = (state_q == S_DONE);
  end

  // Capture datapath: shift, count, and memory write port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      target_q      <= '0;
      bit_cnt_q     <= '0;
      shreg_q       <= '0;
      wr_ptr_q      <= '0;
      mem_we        <= 1'b0;
      mem_waddr     <= '0;
      mem_din       <= '0;
      bytes_written <= '0;
      ones_count    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            target_q      <= tgt_clamp;
            bit_cnt_q     <= '0;
            shreg_q       <= '0;
            wr_ptr_q      <= '0;
            bytes_written <= '0;
            ones_count    <= '0;
          end
        end
        S_COLLECT: begin
          if (xfer) begin
            shreg_q    <= {shreg_q[5:0], bit_data};
            ones_count <= ones_inc;
            bit_cnt_q  <= bit_cnt_q + 3'd1;
            if (last_bit && !abort) begin
              mem_we    <= 1'b1;
              mem_din   <= {shreg_q, bit_data};
              mem_waddr <= wr_ptr_q;
              bit_cnt_q <= '0;
            end
          end
        end
        S_WRITE: begin
          mem_we        <= 1'b0;
          wr_ptr_q      <= wr_ptr_q + 1'b1;
          bytes_written <= bw_inc;
        end
        S_DONE: begin
          mem_we <= 1'b0;
        end
        default: mem_we <= 1'b0;
      endcase
    end
  end

endmodule
